// File: rtl/rtc_alarm_core.sv
// rtc_alarm_core: 1 Hz prescaler, BCD 24-hour time of day, six 7-segment
// digit drivers and NUM_ALARMS alarm channels with snooze and auto-timeout.
module rtc_alarm_core #(
  parameter int CLK_HZ         = 50000000,
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_S       = 300,
  parameter int TIMEOUT_S      = 60,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  time_wr,
  input  logic [23:0]           time_bcd,
  input  logic                  alm_wr,
  input  logic [2:0]            alm_idx,
  input  logic [15:0]           alm_bcd,
  input  logic                  alm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  tick_1hz,
  output logic [7:0]            seg_h1,
  output logic [7:0]            seg_h0,
  output logic [7:0]            seg_m1,
  output logic [7:0]            seg_m0,
  output logic [7:0]            seg_s1,
  output logic [7:0]            seg_s0,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  alarm_any
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RING,
    ST_SNOOZE
  } ch_state_t;

  logic [PW-1:0] presc;
  logic [23:0]   tod;       // {h1,h0,m1,m0,s1,s0}
  logic [23:0]   tod_inc;
  logic          wrap;
  logic          load_q;    // a legal time load happened last cycle
  logic          time_ok;
  logic          alm_ok;

  logic [15:0]           alm_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alm_ena;
  ch_state_t             state_q  [NUM_ALARMS];
  ch_state_t             state_nxt[NUM_ALARMS];
  logic [15:0]           cnt_q    [NUM_ALARMS];
  logic [15:0]           cnt_nxt  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match_v;
  logic [NUM_ALARMS-1:0] wr_hit_v;
  logic [NUM_ALARMS-1:0] ring_nxt;

  function automatic logic hhmm_ok(input logic [15:0] b);
    logic hour_ok;
    hour_ok = ((b[15:12] < 4'd2) && (b[11:8] <= 4'd9)) ||
              ((b[15:12] == 4'd2) && (b[11:8] <= 4'd3));
    return hour_ok && (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] seg_drive(input logic [3:0] d, input logic dp);
    logic [7:0] v;
    v = {dp, seg_code(d)};
    return (SEG_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  localparam logic [7:0] SEG_ZERO = (SEG_ACTIVE_LOW != 0) ? 8'hC0 : 8'h3F;

  // Input legality and prescaler wrap detection.
  always_comb begin
    time_ok = hhmm_ok(time_bcd[23:8]) && (time_bcd[7:4] <= 4'd5) &&
              (time_bcd[3:0] <= 4'd9);
    alm_ok  = hhmm_ok(alm_bcd);
    wrap    = (presc == PW'(CLK_HZ - 1));
  end

  // BCD ripple increment of the time of day, 23:59:59 wraps to 00:00:00.
  always_comb begin
    tod_inc = tod;
    if (tod[3:0] != 4'd9) begin
      tod_inc[3:0] = tod[3:0] + 4'd1;
    end else begin
      tod_inc[3:0] = '0;
      if (tod[7:4] != 4'd5) begin
        tod_inc[7:4] = tod[7:4] + 4'd1;
      end else begin
        tod_inc[7:4] = '0;
        if (tod[11:8] != 4'd9) begin
          tod_inc[11:8] = tod[11:8] + 4'd1;
        end else begin
          tod_inc[11:8] = '0;
          if (tod[15:12] != 4'd5) begin
            tod_inc[15:12] = tod[15:12] + 4'd1;
          end else begin
            tod_inc[15:12] = '0;
            if ((tod[23:20] == 4'd2) && (tod[19:16] == 4'd3)) begin
              tod_inc[23:16] = '0;
            end else if (tod[19:16] == 4'd9) begin
              tod_inc[19:16] = '0;
              tod_inc[23:20] = tod[23:20] + 4'd1;
            end else begin
              tod_inc[19:16] = tod[19:16] + 4'd1;
            end
          end
        end
      end
    end
  end

  // Prescaler, tick pulse and time-of-day register; a legal load beats a tick.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      presc    <= '0;
      tod      <= '0;
      tick_1hz <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      tick_1hz <= wrap;
      load_q   <= time_wr && time_ok;
      if (time_wr && time_ok) begin
        tod   <= time_bcd;
        presc <= '0;
      end else begin
        presc <= wrap ? '0 : presc + 1'b1;
        if (wrap) tod <= tod_inc;
      end
    end
  end

  // Segment drivers, one cycle behind the time and prescaler.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      seg_h1 <= SEG_ZERO;
      seg_h0 <= SEG_ZERO;
      seg_m1 <= SEG_ZERO;
      seg_m0 <= SEG_ZERO;
      seg_s1 <= SEG_ZERO;
      seg_s0 <= SEG_ZERO;
    end else begin
      seg_h1 <= seg_drive(tod[23:20], 1'b0);
      seg_h0 <= seg_drive(tod[19:16], presc < PW'(CLK_HZ / 2));
      seg_m1 <= seg_drive(tod[15:12], 1'b0);
      seg_m0 <= seg_drive(tod[11:8], 1'b0);
      seg_s1 <= seg_drive(tod[7:4], 1'b0);
      seg_s0 <= seg_drive(tod[3:0], 1'b0);
    end
  end

  // Per-channel alarm match (after a tick or a time load) and write select.
  always_comb begin
    match_v  = '0;
    wr_hit_v = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      match_v[i]  = (tick_1hz || load_q) && alm_ena[i] &&
                    (tod[23:8] == alm_time[i]) && (tod[7:0] == 8'h00);
      wr_hit_v[i] = alm_wr && alm_ok && (alm_idx == 3'(i));
    end
  end

  // Channel next state: write > dismiss > snooze > tick timing > match.
  always_comb begin
    ring_nxt = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      state_nxt[i] = state_q[i];
      cnt_nxt[i]   = cnt_q[i];
      if (wr_hit_v[i] || dismiss) begin
        state_nxt[i] = ST_IDLE;
        cnt_nxt[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (match_v[i]) begin
              state_nxt[i] = ST_RING;
              cnt_nxt[i]   = '0;
            end
          end
          ST_RING: begin
            if (snooze) begin
              state_nxt[i] = ST_SNOOZE;
              cnt_nxt[i]   = '0;
            end else if (tick_1hz) begin
              if ((17'(cnt_q[i]) + 17'd1) >= 17'(TIMEOUT_S)) begin
                state_nxt[i] = ST_IDLE;
                cnt_nxt[i]   = '0;
              end else begin
                cnt_nxt[i] = cnt_q[i] + 16'd1;
              end
            end
          end
          ST_SNOOZE: begin
            if (tick_1hz) begin
              if ((17'(cnt_q[i]) + 17'd1) >= 17'(SNOOZE_S)) begin
                state_nxt[i] = ST_RING;
                cnt_nxt[i]   = '0;
              end else begin
                cnt_nxt[i] = cnt_q[i] + 16'd1;
              end
            end
          end
          default: begin
            state_nxt[i] = ST_IDLE;
            cnt_nxt[i]   = '0;
          end
        endcase
      end
      ring_nxt[i] = (state_nxt[i] == ST_RING);
    end
  end

  // Channel state, alarm configuration and registered ringing outputs.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]  <= ST_IDLE;
        cnt_q[i]    <= '0;
        alm_time[i] <= '0;
      end
      alm_ena   <= '0;
      ringing   <= '0;
      alarm_any <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        state_q[i] <= state_nxt[i];
        cnt_q[i]   <= cnt_nxt[i];
        if (wr_hit_v[i]) begin
          alm_time[i] <= alm_bcd;
          alm_ena[i]  <= alm_en;
        end
      end
      ringing   <= ring_nxt;
      alarm_any <= |ring_nxt;
    end
  end

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Self-checking bench for rtc_alarm_core: directed scenarios followed by
// random traffic, compared cycle by cycle with a seconds-of-day model.
module tb_rtc_alarm_core;

  localparam int CLK_HZ         = 4;
  localparam int NA             = 4;
  localparam int SNOOZE_S       = 2;
  localparam int TIMEOUT_S      = 3;
  localparam int SEG_ACTIVE_LOW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          time_wr = 1'b0;
  logic [23:0]   time_bcd = '0;
  logic          alm_wr = 1'b0;
  logic [2:0]    alm_idx = '0;
  logic [15:0]   alm_bcd = '0;
  logic          alm_en = 1'b0;
  logic          snooze = 1'b0;
  logic          dismiss = 1'b0;
  logic          tick_1hz;
  logic [7:0]    seg_h1, seg_h0, seg_m1, seg_m0, seg_s1, seg_s0;
  logic [NA-1:0] ringing;
  logic          alarm_any;

  int checks = 0;
  int failures = 0;

  // Reference model: time as seconds of day, channels as remaining seconds.
  int m_presc, m_tod, m_tick, m_loaded;
  int m_amin [8];
  bit m_aen  [8];
  int m_ring [8];
  int m_snz  [8];
  int m_seg_tod;
  bit m_seg_dp;
  int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  rtc_alarm_core #(
    .CLK_HZ(CLK_HZ),
    .NUM_ALARMS(NA),
    .SNOOZE_S(SNOOZE_S),
    .TIMEOUT_S(TIMEOUT_S),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .time_wr(time_wr),
    .time_bcd(time_bcd),
    .alm_wr(alm_wr),
    .alm_idx(alm_idx),
    .alm_bcd(alm_bcd),
    .alm_en(alm_en),
    .snooze(snooze),
    .dismiss(dismiss),
    .tick_1hz(tick_1hz),
    .seg_h1(seg_h1),
    .seg_h0(seg_h0),
    .seg_m1(seg_m1),
    .seg_m0(seg_m0),
    .seg_s1(seg_s1),
    .seg_s0(seg_s0),
    .ringing(ringing),
    .alarm_any(alarm_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_bcd(input logic [23:0] b);
    int d [6];
    for (int k = 0; k < 6; k++) d[k] = int'(b[4*k +: 4]);
    for (int k = 0; k < 6; k++) if (d[k] > 9) return 1'b0;
    return (d[1] <= 5) && (d[3] <= 5) && (d[5] * 10 + d[4] <= 23);
  endfunction

  function automatic int bcd_to_sec(input logic [23:0] b);
    return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600 +
           (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
           (int'(b[7:4]) * 10 + int'(b[3:0]));
  endfunction

  function automatic logic [23:0] sec_to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] exp_seg(input int digit, input bit dp);
    logic [7:0] v;
    v = {dp, 7'(seg_tab[digit])};
    return (SEG_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_tod = 0; m_tick = 0; m_loaded = 0;
    m_seg_tod = 0; m_seg_dp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      m_amin[c] = 0; m_aen[c] = 1'b0; m_ring[c] = 0; m_snz[c] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit wrap, tok, aok, evt, match;
    wrap = (m_presc == CLK_HZ - 1);
    tok  = time_wr && legal_bcd(time_bcd);
    aok  = alm_wr && legal_bcd({alm_bcd, 8'h00}) && (int'(alm_idx) < NA);
    evt  = (m_tick != 0) || (m_loaded != 0);
    m_seg_tod = m_tod;
    m_seg_dp  = (m_presc < CLK_HZ / 2);
    for (int c = 0; c < NA; c++) begin
      match = evt && m_aen[c] && (m_tod == m_amin[c] * 60);
      if (aok && int'(alm_idx) == c) begin
        m_ring[c] = 0; m_snz[c] = 0;
        m_amin[c] = bcd_to_sec({alm_bcd, 8'h00}) / 60;
        m_aen[c]  = alm_en;
      end else if (dismiss) begin
        m_ring[c] = 0; m_snz[c] = 0;
      end else if (m_ring[c] > 0) begin
        if (snooze) begin
          m_ring[c] = 0; m_snz[c] = SNOOZE_S;
        end else if (m_tick != 0) begin
          m_ring[c]--;
        end
      end else if (m_snz[c] > 0) begin
        if (m_tick != 0) begin
          m_snz[c]--;
          if (m_snz[c] == 0) m_ring[c] = TIMEOUT_S;
        end
      end else if (match) begin
        m_ring[c] = TIMEOUT_S;
      end
    end
    if (tok) begin
      m_tod = bcd_to_sec(time_bcd); m_presc = 0; m_loaded = 1;
    end else begin
      m_loaded = 0;
      m_presc  = wrap ? 0 : m_presc + 1;
      if (wrap) m_tod = (m_tod + 1) % 86400;
    end
    m_tick = wrap ? 1 : 0;
  endtask

  function automatic logic [NA-1:0] exp_ring();
    logic [NA-1:0] r;
    for (int c = 0; c < NA; c++) r[c] = (m_ring[c] > 0);
    return r;
  endfunction

  task automatic check_all();
    int h, m, s;
    h = m_seg_tod / 3600; m = (m_seg_tod / 60) % 60; s = m_seg_tod % 60;
    chk("tick_1hz", 32'(tick_1hz), 32'(m_tick));
    chk("ringing", 32'(ringing), 32'(exp_ring()));
    chk("alarm_any", 32'(alarm_any), 32'(|exp_ring()));
    chk("seg_h1", 32'(seg_h1), 32'(exp_seg(h / 10, 1'b0)));
    chk("seg_h0", 32'(seg_h0), 32'(exp_seg(h % 10, m_seg_dp)));
    chk("seg_m1", 32'(seg_m1), 32'(exp_seg(m / 10, 1'b0)));
    chk("seg_m0", 32'(seg_m0), 32'(exp_seg(m % 10, 1'b0)));
    chk("seg_s1", 32'(seg_s1), 32'(exp_seg(s / 10, 1'b0)));
    chk("seg_s0", 32'(seg_s0), 32'(exp_seg(s % 10, 1'b0)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic clear_strobes();
    time_wr = 1'b0; alm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic wr_time(input logic [23:0] b);
    time_wr = 1'b1; time_bcd = b;
    step();
    time_wr = 1'b0;
  endtask

  task automatic wr_alm(input int idx, input logic [15:0] b, input bit en);
    alm_wr = 1'b1; alm_idx = 3'(idx); alm_bcd = b; alm_en = en;
    step();
    alm_wr = 1'b0;
  endtask

  initial begin
    int n, r, c, t;
    bit done;
    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();

    // Free run from reset: ten seconds after 40 cycles.
    repeat (41) step();
    chk("s1_after_40", 32'(seg_s1), 32'h0000_00F9);
    chk("s0_after_40", 32'(seg_s0), 32'h0000_00C0);

    // Day wrap.
    wr_time(24'h235958);
    repeat (10) step();

    // Illegal hour load is ignored.
    wr_time(24'h7A5959);
    repeat (6) step();

    // Alarm 0 at 06:30 rings after the tick, then times out.
    wr_alm(0, 16'h0630, 1'b1);
    wr_time(24'h062959);
    repeat (20) step();

    // Two channels ring together, snooze, then dismiss on the re-ring tick.
    wr_alm(0, 16'h0700, 1'b1);
    wr_alm(2, 16'h0700, 1'b1);
    wr_time(24'h065959);
    n = 0;
    while (ringing !== 4'b0101 && n < 12) begin step(); n++; end
    chk("ring_ch0_ch2", 32'(ringing), 32'h5);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snoozed", 32'(ringing), 32'h0);
    done = 1'b0;
    for (int k = 0; k < 3 * CLK_HZ + 4 && !done; k++) begin
      if (m_tick != 0 && m_snz[0] == 1) begin
        dismiss = 1'b1;
        done = 1'b1;
      end
      step();
      dismiss = 1'b0;
    end
    chk("dismiss_on_rering_reached", 32'(done), 32'h1);
    repeat (3 * CLK_HZ) step();
    chk("dismissed_idle", 32'(ringing), 32'h0);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        time_wr = 1'b1;
        c = int'($urandom_range(0, NA - 1));
        case ($urandom_range(0, 3))
          0: time_bcd = 24'($urandom());
          1: time_bcd = sec_to_bcd(m_amin[c] * 60);
          default: begin
            t = m_amin[c] * 60 - int'($urandom_range(0, 2));
            if (t < 0) t += 86400;
            time_bcd = sec_to_bcd(t);
          end
        endcase
      end else if (r < 5) begin
        alm_wr  = 1'b1;
        alm_idx = 3'($urandom_range(0, 7));
        alm_en  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) alm_bcd = 16'($urandom());
        else alm_bcd = sec_to_bcd(int'($urandom_range(0, 1439)) * 60) >> 8;
      end else if (r == 5) begin
        snooze = 1'b1;
      end else if (r == 6) begin
        dismiss = 1'b1;
      end
      step();
      clear_strobes();
    end

    // Asynchronous reset in the middle of a ring.
    wr_alm(1, 16'h1200, 1'b1);
    wr_time(24'h120000);
    repeat (2) step();
    chk("pre_reset_ring", 32'(ringing[1]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ringing", 32'(ringing), 32'h0);
    chk("async_rst_any", 32'(alarm_any), 32'h0);
    chk("async_rst_seg_m0", 32'(seg_m0), 32'h0000_00C0);
    chk("async_rst_seg_h1", 32'(seg_h1), 32'h0000_00C0);
    chk("async_rst_seg_h0", 32'(seg_h0), 32'h0000_00C0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
